// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front end.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with a PARITY state).
package uart_pkg;

  localparam int unsigned NBITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_e;

  // Clocks per oversample tick, truncating.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase reset by clr.
module baud_tick_gen #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and tick; clear restarts the phase and suppresses a pending tick.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with a one-byte valid/ready holding register.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(NBITS);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic fall_c, tick, tick_clr_c, commit_c, ferr_c;

  state_e           state_q, state_d;
  logic [OS_W-1:0]  os_q, os_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             busy_q, busy_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic             perr_q, perr_d;
`endif

  // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle-high reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall_c = rx_prev_q & ~rx_sync_q;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst),
    .clr   (tick_clr_c),
    .tick  (tick)
  );

  // Frame FSM: start validation at mid-bit, LSB-first data, optional parity, stop check.
  always_comb begin
    state_d    = state_q;
    os_d       = os_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    tick_clr_c = 1'b0;
    commit_c   = 1'b0;
    ferr_c     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_d    = ST_START;
          os_d       = '0;
          bit_d      = '0;
          tick_clr_c = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_d     = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          if (os_q == OS_HALF) begin
            os_d = '0;
            if (rx_sync_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              busy_d  = 1'b1;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d    = '0;
            shift_d = {rx_sync_q, shift_q[7:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d    = '0;
            perr_d  = ^{shift_q, rx_sync_q};
            state_d = ST_STOP;
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d   = '0;
            busy_d = 1'b0;
            if (!rx_sync_q) begin
              ferr_c  = 1'b1;
              state_d = ST_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            end else if (perr_q) begin
              ferr_c  = 1'b1;
              state_d = ST_IDLE;
`endif
            end else begin
              commit_c = 1'b1;
              state_d  = ST_IDLE;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register: load when empty or being drained, otherwise flag the dropped byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_c;
    ovr_d   = 1'b0;
    if (commit_c) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule
